// File: rtl/mult_share_arbiter.sv
// Round-robin front end that shares one pipelined multiplier among N_REQ requesters.
// Requester IDs travel alongside the multiplier pipeline so each product returns tagged.
module mult_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int IA_W    = 16,
    parameter int IB_W    = 16,
    parameter int STAGES  = 2,
    localparam int ID_W   = $clog2(N_REQ),
    localparam int MUL_W  = IA_W + IB_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*IA_W-1:0]   i_req_a,
    input  logic [N_REQ*IB_W-1:0]   i_req_b,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [IA_W-1:0]         o_mul_a,
    output logic [IB_W-1:0]         o_mul_b,
    output logic                    o_mul_en_ff,
    input  logic [MUL_W-1:0]        i_mul_prod,
    output logic                    o_rsp_valid,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic [MUL_W-1:0]        o_rsp_prod,
    input  logic                    i_rsp_ready,
    output logic                    o_idle
);

    logic [STAGES-1:0] vld;
    logic [ID_W-1:0]   id_pipe [STAGES];
    logic [ID_W-1:0]   ptr;
    logic              en;
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;

    // Modulo-N_REQ add; N_REQ need not be a power of two, so plain wrap of ID_W bits is not enough.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return ID_W'(sum);
    endfunction

    // The tag pipeline and the multiplier stall together only when the head response is blocked.
    assign en          = !vld[STAGES-1] || i_rsp_ready;
    assign o_mul_en_ff = en;

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_found && i_req_valid[wrap_add(ptr, i)]) begin
                grant_found = 1'b1;
                grant_id    = wrap_add(ptr, i);
            end
        end
    end

    // Zero operands when idle so the multiplier is fed zeros on bubble edges.
    always_comb begin
        o_req_ready = '0;
        o_mul_a     = '0;
        o_mul_b     = '0;
        if (grant_found) begin
            o_mul_a = i_req_a[int'(grant_id)*IA_W +: IA_W];
            o_mul_b = i_req_b[int'(grant_id)*IB_W +: IB_W];
            if (en) begin
                o_req_ready[grant_id] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld <= '0;
            ptr <= '0;
            for (int s = 0; s < STAGES; s++) begin
                id_pipe[s] <= '0;
            end
        end else if (en) begin
            vld[0]     <= grant_found;
            id_pipe[0] <= grant_id;
            for (int s = 1; s < STAGES; s++) begin
                vld[s]     <= vld[s-1];
                id_pipe[s] <= id_pipe[s-1];
            end
            if (grant_found) begin
                ptr <= wrap_add(grant_id, 1);
            end
        end
    end

    assign o_rsp_valid = vld[STAGES-1];
    assign o_rsp_id    = id_pipe[STAGES-1];
    assign o_rsp_prod  = i_mul_prod;
    assign o_idle      = ~|vld;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: a STAGES=2 instance and a STAGES=1 instance,
// each attached to a behavioural pipelined multiplier.
module tb_mult_share_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // STAGES=2 instance signals
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic [15:0] mul_a, mul_b;
    logic        mul_en_ff;
    logic [31:0] mul_prod;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_prod;
    logic        rsp_ready;
    logic        idle;

    // STAGES=1 instance signals
    logic        s1_rst;
    logic [3:0]  s1_req_valid;
    logic [63:0] s1_req_a, s1_req_b;
    logic [3:0]  s1_req_ready;
    logic [15:0] s1_mul_a, s1_mul_b;
    logic        s1_mul_en_ff;
    logic [31:0] s1_mul_prod;
    logic        s1_rsp_valid;
    logic [1:0]  s1_rsp_id;
    logic [31:0] s1_rsp_prod;
    logic        s1_rsp_ready;
    logic        s1_idle;

    mult_share_arbiter #(.N_REQ(4), .IA_W(16), .IB_W(16), .STAGES(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
        .o_req_ready(req_ready), .o_mul_a(mul_a), .o_mul_b(mul_b), .o_mul_en_ff(mul_en_ff),
        .i_mul_prod(mul_prod), .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
        .o_rsp_prod(rsp_prod), .i_rsp_ready(rsp_ready), .o_idle(idle)
    );

    mult_share_arbiter #(.N_REQ(4), .IA_W(16), .IB_W(16), .STAGES(1)) dut1 (
        .i_clk(clk), .i_rst(s1_rst), .i_req_valid(s1_req_valid), .i_req_a(s1_req_a), .i_req_b(s1_req_b),
        .o_req_ready(s1_req_ready), .o_mul_a(s1_mul_a), .o_mul_b(s1_mul_b), .o_mul_en_ff(s1_mul_en_ff),
        .i_mul_prod(s1_mul_prod), .o_rsp_valid(s1_rsp_valid), .o_rsp_id(s1_rsp_id),
        .o_rsp_prod(s1_rsp_prod), .i_rsp_ready(s1_rsp_ready), .o_idle(s1_idle)
    );

    // Behavioural multipliers: capture on enabled edges, freeze otherwise.
    logic [31:0] mpipe [2];
    always @(posedge clk) begin
        if (mul_en_ff) begin
            mpipe[0] <= 32'(mul_a) * 32'(mul_b);
            mpipe[1] <= mpipe[0];
        end
    end
    assign mul_prod = mpipe[1];

    logic [31:0] s1_mpipe;
    always @(posedge clk) begin
        if (s1_mul_en_ff) begin
            s1_mpipe <= 32'(s1_mul_a) * 32'(s1_mul_b);
        end
    end
    assign s1_mul_prod = s1_mpipe;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic [15:0] a, input logic [15:0] b);
        req_a[k*16 +: 16] = a;
        req_b[k*16 +: 16] = b;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; s1_rst = 1'b1;
        req_valid = '0; s1_req_valid = '0;
        req_a = '0; req_b = '0; s1_req_a = '0; s1_req_b = '0;
        rsp_ready = 1'b1; s1_rsp_ready = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("[TB] FAIL reset_rsp_id got=%0h exp=0", rsp_id); end
        checks++; if (idle !== 1'b1) begin failures++; $display("[TB] FAIL reset_idle got=%0h exp=1", idle); end
        checks++; if (mul_en_ff !== 1'b1) begin failures++; $display("[TB] FAIL reset_en got=%0h exp=1", mul_en_ff); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ready_none got=%0h exp=0", req_ready); end
        checks++; if (s1_idle !== 1'b1) begin failures++; $display("[TB] FAIL reset_s1_idle got=%0h exp=1", s1_idle); end
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("[TB] FAIL reset_ready_comb got=%0h exp=2", req_ready); end
        req_valid = '0;
        tick();
        rst = 1'b0; s1_rst = 1'b0;
    endtask

    task automatic test_single;
        req_valid = 4'b0100;
        set_op(2, 16'd3, 16'd5);
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("[TB] FAIL single_ready got=%0h exp=4", req_ready); end
        checks++; if (mul_a !== 16'd3 || mul_b !== 16'd5) begin failures++; $display("[TB] FAIL single_operands got=%0h/%0h exp=3/5", mul_a, mul_b); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (idle !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_inflight got=idle%0h/v%0h exp=idle0/v0", idle, rsp_valid); end
        checks++; if (mul_a !== 16'd0) begin failures++; $display("[TB] FAIL single_idle_operand got=%0h exp=0", mul_a); end
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin failures++; $display("[TB] FAIL single_rsp got=v%0h/id%0h exp=v1/id2", rsp_valid, rsp_id); end
        checks++; if (rsp_prod !== 32'd15) begin failures++; $display("[TB] FAIL single_prod got=%0h exp=f", rsp_prod); end
        tick();
        #1;
        checks++; if (idle !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_drain got=idle%0h/v%0h exp=idle1/v0", idle, rsp_valid); end
    endtask

    task automatic test_round_robin;
        int rid;
        logic [31:0] exp_prod;
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_op(k, 16'(10 + k), 16'(20 + k));
        end
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) begin
                checks++;
                if (req_ready !== 4'(1 << (c % 4))) begin
                    failures++; $display("[TB] FAIL rr_grant c=%0d got=%0h exp=%0h", c, req_ready, 4'(1 << (c % 4)));
                end
            end
            if (c >= 2) begin
                rid = (c - 2) % 4;
                exp_prod = 32'((10 + rid) * (20 + rid));
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(rid) || rsp_prod !== exp_prod) begin
                    failures++; $display("[TB] FAIL rr_rsp c=%0d got=v%0h/id%0h/%0h exp=v1/id%0h/%0h", c, rsp_valid, rsp_id, rsp_prod, rid, exp_prod);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        set_op(0, 16'd2, 16'd3);
        set_op(1, 16'd4, 16'd5);
        set_op(2, 16'd6, 16'd7);
        rsp_ready = 1'b0;
        req_valid = 4'b0111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL bp_grant0 got=%0h exp=1", req_ready); end
        tick();
        req_valid = 4'b0110;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("[TB] FAIL bp_grant1 got=%0h exp=2", req_ready); end
        tick();
        req_valid = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (mul_en_ff !== 1'b0 || req_ready !== 4'b0000) begin
                failures++; $display("[TB] FAIL bp_stall c=%0d got=en%0h/rdy%0h exp=en0/rdy0", c, mul_en_ff, req_ready);
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_prod !== 32'd6) begin
                failures++; $display("[TB] FAIL bp_frozen c=%0d got=v%0h/id%0h/%0h exp=v1/id0/6", c, rsp_valid, rsp_id, rsp_prod);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("[TB] FAIL bp_release_grant got=%0h exp=4", req_ready); end
        checks++; if (rsp_id !== 2'd0 || rsp_prod !== 32'd6) begin failures++; $display("[TB] FAIL bp_drain0 got=id%0h/%0h exp=id0/6", rsp_id, rsp_prod); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_prod !== 32'd20) begin failures++; $display("[TB] FAIL bp_drain1 got=v%0h/id%0h/%0h exp=v1/id1/14", rsp_valid, rsp_id, rsp_prod); end
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_prod !== 32'd42) begin failures++; $display("[TB] FAIL bp_drain2 got=v%0h/id%0h/%0h exp=v1/id2/2a", rsp_valid, rsp_id, rsp_prod); end
        tick();
        #1;
        checks++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin failures++; $display("[TB] FAIL bp_empty got=v%0h/idle%0h exp=v0/idle1", rsp_valid, idle); end
    endtask

    task automatic test_fairness_wrap;
        logic [3:0] exp_rdy [3];
        exp_rdy[0] = 4'b1000;
        exp_rdy[1] = 4'b0010;
        exp_rdy[2] = 4'b1000;
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("[TB] FAIL fair_setup got=%0h exp=4", req_ready); end
        tick();
        req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready !== exp_rdy[c]) begin
                failures++; $display("[TB] FAIL fair_grant c=%0d got=%0h exp=%0h", c, req_ready, exp_rdy[c]);
            end
            tick();
        end
        req_valid = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_midflight;
        rsp_ready = 1'b1;
        req_valid = 4'b0011;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL mid_grant0 got=%0h exp=1", req_ready); end
        tick();
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("[TB] FAIL mid_grant1 got=%0h exp=2", req_ready); end
        tick();
        rst = 1'b1;
        req_valid = 4'b0100;
        tick();
        rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
                failures++; $display("[TB] FAIL mid_flushed c=%0d got=v%0h/idle%0h exp=v0/idle1", c, rsp_valid, idle);
            end
            tick();
        end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL mid_ptr_reset got=%0h exp=1", req_ready); end
        tick();
        req_valid = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_stages1_toggle;
        logic [1:0]  op_id [8];
        logic [15:0] op_a  [8];
        logic [15:0] op_b  [8];
        logic [31:0] exp_prod;
        int issue, got, cyc;
        bit gap, hs;
        op_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        op_a  = '{16'd7, 16'd100, 16'hFFFF, 16'd0, 16'd12, 16'd300, 16'h8000, 16'd1};
        op_b  = '{16'd9, 16'd200, 16'hFFFF, 16'd55, 16'd13, 16'd3, 16'd2, 16'hFFFF};
        issue = 0; got = 0; cyc = 0; gap = 1'b0;
        while (got < 8 && cyc < 300) begin
            s1_rsp_ready = (cyc % 2) == 1;
            s1_req_valid = '0;
            hs = 1'b0;
            if (issue < 8 && !gap) begin
                s1_req_valid[op_id[issue]] = 1'b1;
                s1_req_a[int'(op_id[issue])*16 +: 16] = op_a[issue];
                s1_req_b[int'(op_id[issue])*16 +: 16] = op_b[issue];
            end
            #1;
            if (s1_rsp_valid && s1_rsp_ready) begin
                exp_prod = 32'(op_a[got]) * 32'(op_b[got]);
                checks++;
                if (s1_rsp_id !== op_id[got] || s1_rsp_prod !== exp_prod) begin
                    failures++; $display("[TB] FAIL s1_rsp n=%0d got=id%0h/%0h exp=id%0h/%0h", got, s1_rsp_id, s1_rsp_prod, op_id[got], exp_prod);
                end
                got++;
            end
            if (issue < 8 && !gap) begin
                hs = s1_req_ready[op_id[issue]];
            end
            tick();
            if (hs) begin
                issue++;
                gap = 1'b1;
            end else begin
                gap = 1'b0;
            end
            cyc++;
        end
        checks++; if (got != 8) begin failures++; $display("[TB] FAIL s1_count got=%0d exp=8", got); end
        s1_req_valid = '0;
        s1_rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (s1_rsp_valid !== 1'b0 || s1_idle !== 1'b1) begin
                failures++; $display("[TB] FAIL s1_no_extra c=%0d got=v%0h/idle%0h exp=v0/idle1", c, s1_rsp_valid, s1_idle);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fairness_wrap();
        test_reset_midflight();
        test_stages1_toggle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
